// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the converter state encoding, the blank-digit code for SEG7DEC,
// the add-3 correction threshold and the scratch nibble count.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    // SEG7DEC decodes anything above 9 to all segments off.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    // Hundreds, tens and ones nibbles of the scratch register.
    localparam int unsigned NIBBLES = 3;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble nibble correction: adds 3 to a BCD nibble
// that is 5 or more, so that the following left shift carries correctly
// into the next decimal digit.
// Ports:
//   nib_i  in  4  scratch nibble before correction
//   nib_o  out 4  corrected nibble
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Inputs are always 0..9 here, so the sum never exceeds 4'd12.
    assign nib_o = (nib_i >= ADD3_THRESH) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the tens and
// ones 7-segment decoders. START is accepted only in IDLE; the value is
// shifted in MSB first, one bit per clock, and the registered digits are
// updated on the edge that completes the last shift, with a one-cycle DONE.
// Configuration macro: BCD_OVF_BLANK_EN -- when defined, an out-of-range
// result (>99) drives both digits to the blank code instead of value mod 100.
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_ni   in   1      asynchronous active-low reset
//   start_i  in   1      conversion request, sampled only in IDLE
//   bin_i    in   BIN_W  binary value captured with START
//   busy_o   out  1      conversion in progress (SHIFT or DONE)
//   done_o   out  1      one-cycle pulse, digits just updated
//   ten_o    out  4      tens digit
//   one_o    out  4      ones digit
//   ovf_o    out  1      last converted value was above 99
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       ten_o,
    output logic [3:0]       one_o,
    output logic             ovf_o
);

    localparam int unsigned SCR_W = 4 * NIBBLES;

    bcd_state_e       state_q;
    logic [BIN_W-1:0] sh_q;
    logic [SCR_W-1:0] scr_q;
    logic [3:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       ten_q;
    logic [3:0]       one_q;
    logic             ovf_q;

    logic [SCR_W-1:0] scr_adj;
    logic [SCR_W-1:0] scr_d;
    logic [BIN_W-1:0] sh_d;
    logic             last_shift;
    logic             ovf_d;
    logic [3:0]       ten_d;
    logic [3:0]       one_d;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (scr_q[4*g +: 4]),
            .nib_o (scr_adj[4*g +: 4])
        );
    end

    always_comb begin
        scr_d      = {scr_adj[SCR_W-2:0], sh_q[BIN_W-1]};
        sh_d       = {sh_q[BIN_W-2:0], 1'b0};
        last_shift = (cnt_q == 4'(BIN_W - 1));
        // Any bit leaving the hundreds nibble would also mean out of range.
        ovf_d      = (scr_d[SCR_W-1 -: 4] != 4'd0) | scr_adj[SCR_W-1];
`ifdef BCD_OVF_BLANK_EN
        ten_d      = ovf_d ? DIGIT_BLANK : scr_d[7:4];
        one_d      = ovf_d ? DIGIT_BLANK : scr_d[3:0];
`else
        ten_d      = scr_d[7:4];
        one_d      = scr_d[3:0];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ten_q   <= '0;
            one_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i) begin
                        sh_q    <= bin_i;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    scr_q <= scr_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (last_shift) begin
                        ten_q   <= ten_d;
                        one_q   <= one_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign ten_o  = ten_q;
    assign one_o  = one_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 7-bit and an 8-bit instance,
// a cycle-level behavioural model per instance, directed scenarios with
// literal expectations and a randomized stimulus phase.
module tb_bin_to_bcd_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start7 = 1'b0;
    logic       start8 = 1'b0;
    logic [6:0] bin7 = '0;
    logic [7:0] bin8 = '0;

    logic       busy7, done7, ovf7;
    logic [3:0] ten7, one7;
    logic       busy8, done8, ovf8;
    logic [3:0] ten8, one8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(7)) u_dut7 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start7),
        .bin_i   (bin7),
        .busy_o  (busy7),
        .done_o  (done7),
        .ten_o   (ten7),
        .one_o   (one7),
        .ovf_o   (ovf7)
    );

    bin_to_bcd_seq #(.BIN_W(8)) u_dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start8),
        .bin_i   (bin8),
        .busy_o  (busy8),
        .done_o  (done8),
        .ten_o   (ten8),
        .one_o   (one8),
        .ovf_o   (ovf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {ovf, ten, one} for a converted value.
    function automatic logic [8:0] model_res(input int v);
        logic       o;
        logic [3:0] t;
        logic [3:0] u;
        o = (v > 99);
        t = 4'((v % 100) / 10);
        u = 4'(v % 10);
`ifdef BCD_OVF_BLANK_EN
        if (o) begin
            t = 4'hF;
            u = 4'hF;
        end
`endif
        return {o, t, u};
    endfunction

    // Model: cycles left in the current conversion (0 = idle). A conversion
    // is busy for width+1 cycles; the last of them carries DONE.
    int         m7_cnt, m7_val, m8_cnt, m8_val;
    logic [8:0] m7_res, m8_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m7_cnt <= 0;
            m7_val <= 0;
            m7_res <= '0;
        end else if (m7_cnt == 0) begin
            if (start7) begin
                m7_cnt <= 8;
                m7_val <= int'(bin7);
            end
        end else begin
            m7_cnt <= m7_cnt - 1;
            if (m7_cnt == 2) m7_res <= model_res(m7_val);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_cnt <= 0;
            m8_val <= 0;
            m8_res <= '0;
        end else if (m8_cnt == 0) begin
            if (start8) begin
                m8_cnt <= 9;
                m8_val <= int'(bin8);
            end
        end else begin
            m8_cnt <= m8_cnt - 1;
            if (m8_cnt == 2) m8_res <= model_res(m8_val);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy7", 32'(busy7), 32'(m7_cnt != 0));
            chk("done7", 32'(done7), 32'(m7_cnt == 1));
            chk("res7", 32'({ovf7, ten7, one7}), 32'(m7_res));
            chk("busy8", 32'(busy8), 32'(m8_cnt != 0));
            chk("done8", 32'(done8), 32'(m8_cnt == 1));
            chk("res8", 32'({ovf8, ten8, one8}), 32'(m8_res));
        end
    end

    // Start one conversion on the 7-bit instance; lat counts negedges from
    // the one after the accepting edge until DONE is seen (0 on timeout).
    task automatic conv7(input int v, output logic [8:0] res, output int lat);
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'(v);
        @(negedge clk);
        start7 = 1'b0;
        chk("busy_after_start", 32'(busy7), 32'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done7) begin
                lat = i;
                break;
            end
        end
        res = {ovf7, ten7, one7};
        @(negedge clk);
    endtask

    logic [8:0] res, first_res, second_res;
    int         lat, ndone, d1, d2;

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(busy7), 32'd0);
        chk("rst_done", 32'(done7), 32'd0);
        chk("rst_res", 32'({ovf7, ten7, one7}), 32'd0);
        chk("rst_res8", 32'({ovf8, ten8, one8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 42 -> 4,2, DONE seven negedges after the first busy cycle
        conv7(42, res, lat);
        chk("lat42", 32'(lat), 32'd7);
        chk("res42", 32'(res), 32'h042);

        // 0 then 99, holding in between
        conv7(0, res, lat);
        chk("res0", 32'(res), 32'h000);
        repeat (5) @(negedge clk);
        chk("hold0", 32'({ovf7, ten7, one7}), 32'h000);
        conv7(99, res, lat);
        chk("res99", 32'(res), 32'h099);
        repeat (4) @(negedge clk);
        chk("hold99", 32'({ovf7, ten7, one7}), 32'h099);

        // 123 overflows
        conv7(123, res, lat);
`ifdef BCD_OVF_BLANK_EN
        chk("res123", 32'(res), 32'h1FF);
`else
        chk("res123", 32'(res), 32'h123);
`endif

        // START during SHIFT and during DONE is ignored
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'd7;
        @(negedge clk);
        start7 = 1'b0;
        ndone  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start7 = 1'b0;
            if (i == 3) begin
                start7 = 1'b1;
                bin7   = 7'd100;
            end
            if (done7) begin
                ndone++;
                res = {ovf7, ten7, one7};
                if (ndone == 1) start7 = 1'b1;
            end
        end
        start7 = 1'b0;
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_res", 32'(res), 32'h007);

        // Reset three cycles into a conversion
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'd42;
        @(negedge clk);
        start7 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy7), 32'd0);
        chk("abort_done", 32'(done7), 32'd0);
        chk("abort_res", 32'({ovf7, ten7, one7}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        conv7(42, res, lat);
        chk("after_rst_lat", 32'(lat), 32'd7);
        chk("after_rst_res", 32'(res), 32'h042);

        // START held high: back-to-back conversions every 9 clocks
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'd55;
        ndone  = 0;
        d1     = 0;
        d2     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done7) begin
                ndone++;
                if (ndone == 1) begin
                    d1        = i;
                    first_res = {ovf7, ten7, one7};
                    bin7      = 7'd77;
                end else begin
                    d2         = i;
                    second_res = {ovf7, ten7, one7};
                    start7     = 1'b0;
                    break;
                end
            end
        end
        start7 = 1'b0;
        chk("held_ndone", 32'(ndone), 32'd2);
        chk("held_interval", 32'(d2 - d1), 32'd9);
        chk("held_res55", 32'(first_res), 32'h055);
        chk("held_res77", 32'(second_res), 32'h077);
        repeat (3) @(negedge clk);

        // 8-bit instance, 255
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd255;
        @(negedge clk);
        start8 = 1'b0;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        chk("lat255", 32'(lat), 32'd8);
`ifdef BCD_OVF_BLANK_EN
        chk("res255", 32'({ovf8, ten8, one8}), 32'h1FF);
`else
        chk("res255", 32'({ovf8, ten8, one8}), 32'h155);
`endif

        // Randomized phase: random requests, values and rare resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
            end
            start7 = ($urandom_range(0, 2) == 0);
            bin7   = 7'($urandom);
            start8 = ($urandom_range(0, 3) == 0);
            bin8   = 8'($urandom);
        end
        rst_n  = 1'b1;
        start7 = 1'b0;
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
